// File: rtl/conv1d_pkg.sv
// conv1d_pool shared types and arithmetic helpers.
// FSM state encoding, accumulator sizing, saturating rescale.
package conv1d_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DATA,
    S_MAC,
    S_POST,
    S_WAIT
  } state_e;

  localparam int SAT_W = 64;

  function automatic int acc_w(input int dw, input int taps);
    return 2 * dw + $clog2(taps) + 1;
  endfunction

  function automatic int fx_one(input int frac);
    return 1 << frac;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] v,
    input int                      frac,
    input int                      dw
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s  = v >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/conv1d_pool_pe.sv
// conv1d_pe: SIZE_K-tap signed multiply-add for one pool position.
// Products are full 2*DW wide, summed at ACC_W.
module conv1d_pe #(
  parameter int DW     = 16,
  parameter int SIZE_K = 3,
  parameter int ACC_W  = 36
) (
  input  logic [SIZE_K*DW-1:0]    i_x,
  input  logic [SIZE_K*DW-1:0]    i_w,
  output logic signed [ACC_W-1:0] o_sum
);

  logic signed [DW-1:0]   xs;
  logic signed [DW-1:0]   ws;
  logic signed [2*DW-1:0] prod;

  // sum of tap products
  always_comb begin
    o_sum = '0;
    xs    = '0;
    ws    = '0;
    prod  = '0;
    for (int k = 0; k < SIZE_K; k++) begin
      xs    = i_x[k*DW +: DW];
      ws    = i_w[k*DW +: DW];
      prod  = xs * ws;
      o_sum = o_sum + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv1d_pool.sv
// conv1d_pool: 1-D conv + bias + optional ReLU + max-pool.
// Define CONV1D_RELU_EN to clamp negatives to 0 before pooling.
module conv1d_pool
  import conv1d_pkg::*;
#(
  parameter int DW     = 16,
  parameter int FRAC   = 8,
  parameter int IN_CH  = 2,
  parameter int OUT_CH = 4,
  parameter int SIZE_K = 3,
  parameter int STRIDE = 1,
  parameter int POOL   = 2
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic                 i_EN_w,
  input  logic                 i_EN_c,
  output logic                 o_busy,
  input  logic [DW*IN_CH-1:0]  i_data,
  input  logic                 i_stb_in,
  output logic                 o_ack_in,
  output logic [DW*OUT_CH-1:0] o_data,
  output logic                 o_stb_out,
  input  logic                 i_ack_out
);

  localparam int ACC_W = acc_w(DW, IN_CH * SIZE_K);
  localparam int BUF_L = SIZE_K + STRIDE * (POOL - 1);
  localparam int WIN   = POOL * STRIDE;
  localparam int CW    = $clog2(WIN + 1);
  localparam int OW    = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam int CHW   = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int KW    = (SIZE_K > 1) ? $clog2(SIZE_K) : 1;

  state_e state_q, state_d;

  logic signed [DW-1:0] w_q [OUT_CH][IN_CH][SIZE_K];
  logic signed [DW-1:0] w_d [OUT_CH][IN_CH][SIZE_K];
  logic signed [DW-1:0] bias_q [OUT_CH];
  logic signed [DW-1:0] bias_d [OUT_CH];
  logic signed [DW-1:0] buf_q [IN_CH][BUF_L];
  logic signed [DW-1:0] buf_d [IN_CH][BUF_L];
  logic signed [ACC_W-1:0] acc_q [POOL];
  logic signed [ACC_W-1:0] acc_d [POOL];
  logic signed [DW-1:0] res_q [OUT_CH];
  logic signed [DW-1:0] res_d [OUT_CH];

  logic [DW*OUT_CH-1:0] data_q, data_d;
  logic                 stb_q, stb_d;
  logic                 ack_q, ack_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OW-1:0]        o_q, o_d;
  logic [CHW-1:0]       c_q, c_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 bph_q, bph_d;

  logic                    xfer;
  logic [SIZE_K*DW-1:0]    pe_x [POOL];
  logic [SIZE_K*DW-1:0]    pe_w [POOL];
  logic signed [ACC_W-1:0] pe_sum [POOL];
  logic signed [DW-1:0]    bsel;
  logic signed [SAT_W-1:0] v;
  logic signed [DW-1:0]    t;
  logic signed [DW-1:0]    mx;

  assign xfer = i_stb_in && ack_q;

  // select the (o, c) window and weights for the PEs
  always_comb begin
    for (int p = 0; p < POOL; p++) begin
      pe_x[p] = '0;
      pe_w[p] = '0;
    end
    for (int o = 0; o < OUT_CH; o++)
      for (int c = 0; c < IN_CH; c++)
        if (o_q == OW'(o) && c_q == CHW'(c))
          for (int p = 0; p < POOL; p++)
            for (int k = 0; k < SIZE_K; k++) begin
              pe_x[p][k*DW +: DW] = buf_q[c][p*STRIDE+k];
              pe_w[p][k*DW +: DW] = w_q[o][c][k];
            end
  end

  for (genvar p = 0; p < POOL; p++) begin : g_pe
    conv1d_pe #(
      .DW    (DW),
      .SIZE_K(SIZE_K),
      .ACC_W (ACC_W)
    ) u_pe (
      .i_x  (pe_x[p]),
      .i_w  (pe_w[p]),
      .o_sum(pe_sum[p])
    );
  end

  // state register
  always_ff @(posedge clk) begin
    if (!RSTn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_EN_w && !i_EN_c)      state_d = S_LOAD;
        else if (!i_EN_w && i_EN_c) state_d = S_DATA;
      end
      S_LOAD:
        if (xfer && bph_q && o_q == OW'(OUT_CH - 1))
          state_d = S_IDLE;
      S_DATA:
        if (cnt_q == CW'(WIN)) state_d = S_MAC;
      S_MAC:
        if (c_q == CHW'(IN_CH - 1)) state_d = S_POST;
      S_POST:
        state_d = (o_q == OW'(OUT_CH - 1)) ? S_WAIT : S_MAC;
      S_WAIT:
        if (!stb_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath next values
  always_comb begin
    w_d    = w_q;
    bias_d = bias_q;
    buf_d  = buf_q;
    acc_d  = acc_q;
    res_d  = res_q;
    data_d = data_q;
    stb_d  = stb_q;
    cnt_d  = cnt_q;
    o_d    = o_q;
    c_d    = c_q;
    k_d    = k_q;
    bph_d  = bph_q;
    bsel   = '0;
    v      = '0;
    t      = '0;
    mx     = '0;
    ack_d  = 1'b0;
    if (stb_q && i_ack_out) stb_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        for (int p = 0; p < POOL; p++) acc_d[p] = '0;
        cnt_d = '0;
        o_d   = '0;
        c_d   = '0;
        k_d   = KW'(SIZE_K - 1);
        bph_d = 1'b0;
      end
      S_LOAD: if (xfer) begin
        if (!bph_q) begin
          for (int o = 0; o < OUT_CH; o++)
            for (int c = 0; c < IN_CH; c++)
              for (int k = 0; k < SIZE_K; k++)
                if (o_q == OW'(o) && k_q == KW'(k))
                  w_d[o][c][k] = i_data[c*DW +: DW];
          if (k_q == '0) begin
            k_d = KW'(SIZE_K - 1);
            o_d = o_q + 1'b1;
            if (o_q == OW'(OUT_CH - 1)) begin
              o_d   = '0;
              bph_d = 1'b1;
            end
          end else begin
            k_d = k_q - 1'b1;
          end
        end else begin
          for (int o = 0; o < OUT_CH; o++)
            if (o_q == OW'(o)) bias_d[o] = i_data[DW-1:0];
          o_d = o_q + 1'b1;
        end
      end
      S_DATA: if (xfer) begin
        for (int c = 0; c < IN_CH; c++) begin
          for (int j = BUF_L - 1; j > 0; j--)
            buf_d[c][j] = buf_q[c][j-1];
          buf_d[c][0] = i_data[c*DW +: DW];
        end
        cnt_d = cnt_q + 1'b1;
      end
      S_MAC: begin
        for (int p = 0; p < POOL; p++)
          acc_d[p] = acc_q[p] + pe_sum[p];
        c_d = c_q + 1'b1;
      end
      S_POST: begin
        for (int o = 0; o < OUT_CH; o++)
          if (o_q == OW'(o)) bsel = bias_q[o];
        for (int p = 0; p < POOL; p++) begin
          v = SAT_W'(acc_q[p]) + (SAT_W'(bsel) <<< FRAC);
          t = DW'(sat_shift(v, FRAC, DW));
`ifdef CONV1D_RELU_EN
          if (t < 0) t = '0;
`else
`endif
          if (p == 0 || t > mx) mx = t;
          acc_d[p] = '0;
        end
        for (int o = 0; o < OUT_CH; o++)
          if (o_q == OW'(o)) res_d[o] = mx;
        c_d = '0;
        o_d = o_q + 1'b1;
      end
      S_WAIT: if (!stb_q) begin
        for (int o = 0; o < OUT_CH; o++)
          data_d[o*DW +: DW] = res_q[o];
        stb_d = 1'b1;
      end
      default: ;
    endcase
    if (state_q == S_LOAD)
      ack_d = !xfer && state_d == S_LOAD;
    else if (state_q == S_DATA)
      ack_d = !xfer && cnt_d != CW'(WIN);
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      for (int o = 0; o < OUT_CH; o++) begin
        for (int c = 0; c < IN_CH; c++)
          for (int k = 0; k < SIZE_K; k++)
            w_q[o][c][k] <= '0;
        bias_q[o] <= '0;
        res_q[o]  <= '0;
      end
      for (int c = 0; c < IN_CH; c++)
        for (int j = 0; j < BUF_L; j++)
          buf_q[c][j] <= '0;
      for (int p = 0; p < POOL; p++) acc_q[p] <= '0;
      data_q <= '0;
      stb_q  <= 1'b0;
      ack_q  <= 1'b0;
      cnt_q  <= '0;
      o_q    <= '0;
      c_q    <= '0;
      k_q    <= KW'(SIZE_K - 1);
      bph_q  <= 1'b0;
    end else begin
      w_q    <= w_d;
      bias_q <= bias_d;
      buf_q  <= buf_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
      data_q <= data_d;
      stb_q  <= stb_d;
      ack_q  <= ack_d;
      cnt_q  <= cnt_d;
      o_q    <= o_d;
      c_q    <= c_d;
      k_q    <= k_d;
      bph_q  <= bph_d;
    end
  end

  // outputs
  always_comb begin
    o_busy    = state_q != S_IDLE;
    o_ack_in  = ack_q;
    o_data    = data_q;
    o_stb_out = stb_q;
  end

endmodule

// File: tb/tb_conv1d_pool.sv
// Testbench for conv1d_pool against a sample-history reference.
// Honours CONV1D_RELU_EN the same way as the design build.
module tb_conv1d_pool;

  localparam int DW     = 16;
  localparam int FRAC   = 8;
  localparam int IN_CH  = 1;
  localparam int OUT_CH = 2;
  localparam int SIZE_K = 3;
  localparam int STRIDE = 1;
  localparam int POOL   = 2;
  localparam int WIN    = POOL * STRIDE;
  localparam int BUF_L  = SIZE_K + STRIDE * (POOL - 1);
  localparam int LAT    = OUT_CH * (IN_CH + 1) + 2;

  logic clk = 1'b0;
  logic RSTn = 1'b0;
  logic i_EN_w = 1'b0;
  logic i_EN_c = 1'b0;
  logic i_stb_in = 1'b0;
  logic i_ack_out = 1'b0;
  logic [DW*IN_CH-1:0] i_data = '0;
  logic o_busy, o_ack_in, o_stb_out;
  logic [DW*OUT_CH-1:0] o_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  longint mw [OUT_CH][IN_CH][SIZE_K];
  longint mb [OUT_CH];
  longint hist [IN_CH][BUF_L];
  logic [DW*IN_CH-1:0] win_s [WIN];
  logic [DW*OUT_CH-1:0] exp_data;
  logic [DW*OUT_CH-1:0] exp1;

  conv1d_pool #(
    .DW(DW), .FRAC(FRAC), .IN_CH(IN_CH), .OUT_CH(OUT_CH),
    .SIZE_K(SIZE_K), .STRIDE(STRIDE), .POOL(POOL)
  ) dut (
    .clk(clk), .RSTn(RSTn), .i_EN_w(i_EN_w), .i_EN_c(i_EN_c),
    .o_busy(o_busy), .i_data(i_data), .i_stb_in(i_stb_in),
    .o_ack_in(o_ack_in), .o_data(o_data), .o_stb_out(o_stb_out),
    .i_ack_out(i_ack_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // one pooled output channel from the sample history
  function automatic logic [DW-1:0] ref_lane(input int o);
    longint acc, val, best;
    best = 0;
    for (int p = 0; p < POOL; p++) begin
      acc = 0;
      for (int c = 0; c < IN_CH; c++)
        for (int k = 0; k < SIZE_K; k++)
          acc += hist[c][p*STRIDE+k] * mw[o][c][k];
      val = (acc + mb[o] * (64'sd1 << FRAC)) >>> FRAC;
      if (val > 32767) val = 32767;
      if (val < -32768) val = -32768;
`ifdef CONV1D_RELU_EN
      if (val < 0) val = 0;
`endif
      if (p == 0 || val > best) best = val;
    end
    return DW'(best);
  endfunction

  function automatic logic [DW*OUT_CH-1:0] ref_data();
    logic [DW*OUT_CH-1:0] r;
    r = '0;
    for (int o = 0; o < OUT_CH; o++) r[o*DW +: DW] = ref_lane(o);
    return r;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < OUT_CH; o++) begin
      mb[o] = 0;
      for (int c = 0; c < IN_CH; c++)
        for (int k = 0; k < SIZE_K; k++) mw[o][c][k] = 0;
    end
    for (int c = 0; c < IN_CH; c++)
      for (int j = 0; j < BUF_L; j++) hist[c][j] = 0;
  endtask

  task automatic model_push(input logic [DW*IN_CH-1:0] d);
    for (int c = 0; c < IN_CH; c++) begin
      for (int j = BUF_L - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
      hist[c][0] = longint'($signed(d[c*DW +: DW]));
    end
  endtask

  task automatic set_all_w(input int wv, input int bv);
    for (int o = 0; o < OUT_CH; o++) begin
      mb[o] = bv;
      for (int c = 0; c < IN_CH; c++)
        for (int k = 0; k < SIZE_K; k++) mw[o][c][k] = wv;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    RSTn = 1'b0;
    i_EN_w = 1'b0;
    i_EN_c = 1'b0;
    i_stb_in = 1'b0;
    i_ack_out = 1'b0;
    repeat (2) @(negedge clk);
    RSTn = 1'b1;
    model_reset();
  endtask

  task automatic pulse(input bit wgt);
    if (wgt) i_EN_w = 1'b1;
    else     i_EN_c = 1'b1;
    @(negedge clk);
    i_EN_w = 1'b0;
    i_EN_c = 1'b0;
  endtask

  // present a beat; t = edge index of the transfer, -1 on timeout
  task automatic send_beat(input logic [DW*IN_CH-1:0] d, output int t);
    bit done;
    done = 1'b0;
    t = -1;
    i_data = d;
    i_stb_in = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (o_ack_in) begin
        t = cyc + 1;
        done = 1'b1;
      end
      @(negedge clk);
    end
    i_stb_in = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: got no ack, want ack within 20 cycles");
    end
  endtask

  task automatic wait_stb(output int ts);
    bit done;
    done = 1'b0;
    ts = -1;
    for (int n = 0; n < 80 && !done; n++) begin
      if (o_stb_out) begin
        ts = cyc;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic load_params();
    int t, nx;
    logic [DW*IN_CH-1:0] d;
    longint tmp;
    nx = 0;
    pulse(1'b1);
    for (int o = 0; o < OUT_CH; o++)
      for (int k = SIZE_K - 1; k >= 0; k--) begin
        for (int c = 0; c < IN_CH; c++) begin
          tmp = mw[o][c][k];
          d[c*DW +: DW] = tmp[DW-1:0];
        end
        send_beat(d, t);
        if (t >= 0) nx++;
      end
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL load_busy: got %b want 1", o_busy);
    end
    for (int o = 0; o < OUT_CH; o++) begin
      d = DW*IN_CH'($urandom);
      tmp = mb[o];
      d[DW-1:0] = tmp[DW-1:0];
      send_beat(d, t);
      if (t >= 0) nx++;
    end
    n_cmp++;
    if (o_busy !== 1'b0 || nx != OUT_CH * (SIZE_K + 1)) begin
      n_bad++;
      $display("FAIL load_done: got busy=%b beats=%0d want busy=0 beats=%0d",
               o_busy, nx, OUT_CH * (SIZE_K + 1));
    end
  endtask

  // run one window from win_s; optionally acknowledge
  task automatic run_window(input string nm, input bit ack);
    int t, ts;
    t = -1;
    pulse(1'b0);
    for (int i = 0; i < WIN; i++) begin
      send_beat(win_s[i], t);
      model_push(win_s[i]);
    end
    exp_data = ref_data();
    wait_stb(ts);
    n_cmp++;
    if (ts != t + LAT) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d want %0d", nm, ts - t, LAT);
    end
    n_cmp++;
    if (o_data !== exp_data) begin
      n_bad++;
      $display("FAIL %s_data: got %h want %h", nm, o_data, exp_data);
    end
    if (ack) begin
      i_ack_out = 1'b1;
      @(negedge clk);
      i_ack_out = 1'b0;
      n_cmp++;
      if (o_stb_out !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_ack: got stb=%b want 0", nm, o_stb_out);
      end
    end
  endtask

  task automatic set_win(input int a, input int b);
    win_s[0] = DW'(a);
    win_s[1] = DW'(b);
  endtask

  task automatic check_lane(input string nm, input int o, input logic [DW-1:0] want);
    n_cmp++;
    if (o_data[o*DW +: DW] !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, o_data[o*DW +: DW], want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({o_busy, o_ack_in, o_stb_out} !== 3'b000 || o_data !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got busy=%b ack=%b stb=%b data=%h want all 0",
               o_busy, o_ack_in, o_stb_out, o_data);
    end
  endtask

  task automatic test_basic();
    set_all_w(16'h0100, 0);
    load_params();
    set_win(16'h0100, 16'h0200);
    run_window("basic", 1'b1);
    check_lane("basic_lane0", 0, 16'h0300);
    check_lane("basic_lane1", 1, 16'h0300);
  endtask

  task automatic test_neg_filter();
    do_reset();
    set_all_w(16'h0100, 0);
    for (int c = 0; c < IN_CH; c++)
      for (int k = 0; k < SIZE_K; k++) mw[1][c][k] = -256;
    load_params();
    set_win(16'h0100, 16'h0200);
    run_window("negf", 1'b1);
    check_lane("negf_lane0", 0, 16'h0300);
`ifdef CONV1D_RELU_EN
    check_lane("negf_lane1", 1, 16'h0000);
`else
    check_lane("negf_lane1", 1, 16'hFF00);
`endif
  endtask

  task automatic test_bias();
    do_reset();
    set_all_w(16'h0100, 0);
    mb[0] = 16'h0080;
    load_params();
    set_win(16'h0100, 16'h0200);
    run_window("bias", 1'b1);
    check_lane("bias_lane0", 0, 16'h0380);
  endtask

  task automatic test_saturation();
    set_all_w(16'h7FFF, 0);
    load_params();
    set_win(16'h7FFF, 16'h7FFF);
    run_window("satp_a", 1'b1);
    run_window("satp_b", 1'b1);
    check_lane("satp_lane0", 0, 16'h7FFF);
    set_win(-32768, -32768);
    run_window("satn_a", 1'b1);
    run_window("satn_b", 1'b1);
`ifdef CONV1D_RELU_EN
    check_lane("satn_lane1", 1, 16'h0000);
`else
    check_lane("satn_lane1", 1, 16'h8000);
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int o = 0; o < OUT_CH; o++) begin
        mb[o] = int'($urandom_range(0, 2047)) - 1024;
        for (int c = 0; c < IN_CH; c++)
          for (int k = 0; k < SIZE_K; k++)
            mw[o][c][k] = int'($urandom_range(0, 1023)) - 512;
      end
      load_params();
      for (int w = 0; w < 2; w++) begin
        for (int i = 0; i < WIN; i++)
          win_s[i] = (it == 3) ? DW'($urandom)
                               : DW'(int'($urandom_range(0, 2047)) - 1024);
        run_window("random", 1'b1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    set_win(16'h0040, 16'hFFC0);
    run_window("stall_first", 1'b0);
    exp1 = exp_data;
    pulse(1'b0);
    win_s[0] = DW'(int'($urandom_range(0, 511)));
    win_s[1] = DW'(int'($urandom_range(0, 511)));
    for (int i = 0; i < WIN; i++) begin
      send_beat(win_s[i], t);
      model_push(win_s[i]);
    end
    exp_data = ref_data();
    repeat (LAT + 4) @(negedge clk);
    n_cmp++;
    if (o_stb_out !== 1'b1 || o_busy !== 1'b1 || o_data !== exp1) begin
      n_bad++;
      $display("FAIL stall_hold: got stb=%b busy=%b data=%h want 1 1 %h",
               o_stb_out, o_busy, o_data, exp1);
    end
    i_ack_out = 1'b1;
    @(negedge clk);
    i_ack_out = 1'b0;
    n_cmp++;
    if (o_stb_out !== 1'b0 || o_data !== exp1) begin
      n_bad++;
      $display("FAIL stall_ack: got stb=%b data=%h want 0 %h", o_stb_out, o_data, exp1);
    end
    @(negedge clk);
    n_cmp++;
    if (o_stb_out !== 1'b1 || o_data !== exp_data || o_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_second: got stb=%b busy=%b data=%h want 1 0 %h",
               o_stb_out, o_busy, o_data, exp_data);
    end
    i_ack_out = 1'b1;
    @(negedge clk);
    i_ack_out = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t;
    set_all_w(16'h0100, 16'h0100);
    load_params();
    set_win(16'h0100, 16'h0200);
    pulse(1'b0);
    for (int i = 0; i < WIN; i++) send_beat(win_s[i], t);
    @(negedge clk);
    RSTn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_busy, o_ack_in, o_stb_out} !== 3'b000 || o_data !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b ack=%b stb=%b data=%h want all 0",
               o_busy, o_ack_in, o_stb_out, o_data);
    end
    RSTn = 1'b1;
    model_reset();
    @(negedge clk);
    set_win(16'h0300, 16'h0500);
    run_window("reset_cleared", 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_neg_filter();
    test_bias();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv1d_pool.md
# conv1d_pool

Parametrised multi-output-channel 1-D convolution layer with fused bias, ReLU and max-pool, for the ECG 1D-CNN accelerator chain. One accepted window of `POOL*STRIDE` new samples (all input channels per beat) yields one pooled, signed fixed-point value per output channel. Weights and biases are loaded over the same stb/ack input port. The block sits between feature-map producers and the next layer, or the dense stage.

## Interface
- `DW`, 16: sample, weight and bias width; signed two's complement.
- `FRAC`, 8: fractional bits of all operands. 1.0 = `1<<FRAC`.
- `IN_CH`, 2: input channels.
- `OUT_CH`, 4: output channels (filters).
- `SIZE_K`, 3: kernel taps.
- `STRIDE`, 1: conv stride.
- `POOL`, 2: max-pool width (≥1).
- `clk`  in  1  clock; all logic on rising edge.
- `RSTn`  in  1  reset; synchronous, active-low.
- `i_EN_w`  in  1  start weight/bias load (sampled in IDLE).
- `i_EN_c`  in  1  start one compute window (sampled in IDLE).
- `o_busy`  out  1  high whenever state ≠ IDLE.
- `i_data`  in  DW*IN_CH  input beat; lane c = `[c*DW +: DW]`.
- `i_stb_in`  in  1  input beat valid.
- `o_ack_in`  out  1  input ready (registered).
- `o_data`  out  DW*OUT_CH  pooled results; lane o = output channel o.
- `o_stb_out`  out  1  output valid.
- `i_ack_out`  in  1  output accepted.

## Operation
- States: IDLE, LOAD, DATA, MAC, POST, WAIT.
- IDLE: `{i_EN_w,i_EN_c}` 10 → LOAD, 01 → DATA, 00/11 → stay. Clears accumulators and beat counter.
- Transfer = `i_stb_in && o_ack_in`. `o_ack_in` is set each cycle in LOAD/DATA and cleared the cycle after every transfer, so the peak rate is 1 beat per 2 cycles.
- LOAD takes `OUT_CH*SIZE_K` weight beats, then `OUT_CH` bias beats, then goes to IDLE.
  - Weight beat order: filter 0 tap `SIZE_K-1` … tap 0, then filter 1, and so on. The last beat of each filter is tap 0.
  - Each weight beat supplies all `IN_CH` lanes. A bias beat uses lane 0; other lanes are ignored.
- DATA shifts `POOL*STRIDE` beats into a per-channel window buffer of length `SIZE_K+STRIDE*(POOL-1)`. Element 0 is the newest. Then it goes to MAC.
- MAC: one cycle per (o, c) pair, with c inner. Each cycle, for every pool position p, it forms Σₖ `buf[c][p*STRIDE+k]*w[o][c][k]` and adds it into `acc[p]`.
- POST: one cycle after the last c of each o:
  - per p: `(acc[p] + (bias[o]<<FRAC)) >>> FRAC`, saturated to DW signed;
  - ReLU (if compiled in);
  - max over p, written to result lane o;
  - clear `acc`, advance o.
- After POST of o = `OUT_CH-1`, go to WAIT.
- WAIT: if `o_stb_out` is low, load `o_data`, set `o_stb_out` and go to IDLE. Otherwise stall.
- `o_stb_out` clears on `o_stb_out && i_ack_out`.
- Arithmetic: products are 2*DW signed. `ACC_W = 2*DW + clog2(IN_CH*SIZE_K) + 1`, so no internal overflow. Saturation clips to [−2^(DW−1), 2^(DW−1)−1].
- Weights, biases and the window buffer persist across windows. They are zero after reset.

## Timing
- Reset values: `o_ack_in`=0, `o_stb_out`=0, `o_data`=0, `o_busy`=0; state IDLE; all weights, biases and buffers 0.
- Reset has priority in any state mid-operation; a partial load or window is discarded.
- Latency: with the last DATA transfer at edge T, `o_stb_out` rises at edge T + `OUT_CH*(IN_CH+1)` + 2, provided no stall in WAIT.
- `o_data` is stable while `o_stb_out` is high. A new result cannot overwrite an unacknowledged one; WAIT stalls.
- Ack and new result on the same edge: `o_stb_out` goes low then, and the new result loads on the next edge.
- `i_EN_*` are ignored outside IDLE.

## Configuration
- `CONV1D_RELU_EN` defined: negative post-saturation values are forced to 0 before pooling.
- Undefined: signed values pass straight to the max-pool.

## Structure
- `conv1d_pkg`: state enum, `ACC_W` function, saturating shift function, fixed-point constants.
- Sub-module `conv1d_pe`: one pool position's `SIZE_K`-tap multiply-add tree for one channel pair. Instantiated `POOL` times.

## Test plan
- Bench setup: DW=16, FRAC=8, IN_CH=1, OUT_CH=2, SIZE_K=3, POOL=2, STRIDE=1.
- Load: all weights 0x0100, biases 0 → `o_busy` drops after 8 transfers. Window {0x0100, 0x0200} → `o_data` = {0x0300, 0x0300} at the stated latency.
- Filter 1 weights 0xFF00 → lane 1 = 0x0000 with ReLU, 0xFF00 without.
- Bias 0x0080 on filter 0, same window → lane 0 = 0x0380.
- Weights 0x7FFF, samples 0x7FFF → lanes saturate to 0x7FFF. Samples 0x8000 with ReLU off → 0x8000.
- Hold `i_ack_out`=0 across two windows → second result stalls in WAIT and the first `o_data` is unchanged. Then ack → the second result appears 1 cycle later.
- Assert `RSTn`=0 mid-MAC → next edge: all outputs zero, state IDLE, previously loaded weights cleared.
